// File: rtl/transformation_engine.sv
`timescale 1ns/1ps
// transformation_engine
// Computes FM x WM. FM is FEATURE_ROWS x FEATURE_COLS and WM is
// FEATURE_COLS x WEIGHT_COLS. All operands come through one shared external
// read port. Each weight column is buffered once in a scratch pad. Every
// feature row is then streamed against that column through a one-cycle
// combinational dot product. Results are kept in an internal
// FEATURE_ROWS x WEIGHT_COLS memory, which the aggregation stage reads by row.
//
// Ports
//   clk, reset    clock and asynchronous active-high reset
//   start         begins a full product; accepted only when idle or done
//   relu_en       clamps negative results to 0 (signed mode), latched at start
//   data_in       FEATURE_COLS packed elements returned by external memory
//   read_row      result-memory row presented on fm_wm_row
//   read_address  external memory address (holds outside request cycles)
//   enable_read   one-cycle external read strobe
//   fm_wm_row     WEIGHT_COLS packed results of row read_row (zero if out of range)
//   busy          high while a product is running
//   done          sticky completion flag, cleared by the next start or reset
module transformation_engine #(
  parameter int FEATURE_ROWS   = 6,
  parameter int FEATURE_COLS   = 96,
  parameter int WEIGHT_COLS    = 3,
  parameter int DATA_WIDTH     = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int WEIGHT_BASE    = 0,
  parameter int FEATURE_BASE   = 512,
  parameter int MEM_LATENCY    = 1,
  parameter bit SIGNED         = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  relu_en,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0]    data_in,
  input  logic [$clog2(FEATURE_ROWS)-1:0]       read_row,
  output logic [ADDRESS_WIDTH-1:0]              read_address,
  output logic                                  enable_read,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row,
  output logic                                  busy,
  output logic                                  done
);

  localparam int RW  = $clog2(FEATURE_ROWS);
  localparam int CW  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int WTW = $clog2(MEM_LATENCY + 1);
  // The full-precision sum needs 2*DATA_WIDTH+$clog2(FEATURE_COLS) bits.
  // One extra bit lets unsigned sums ride in a signed accumulator without
  // wrapping negative. The accumulator is also kept wider than the result,
  // so that the saturation bounds are representable.
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(FEATURE_COLS) + 1;
  localparam int CALC_W = (ACC_W > DOT_PROD_WIDTH + 1) ? ACC_W : DOT_PROD_WIDTH + 1;

  localparam logic signed [CALC_W-1:0] U_MAX =
    {{(CALC_W-DOT_PROD_WIDTH){1'b0}}, {DOT_PROD_WIDTH{1'b1}}};
  localparam logic signed [CALC_W-1:0] S_MAX =
    {{(CALC_W-DOT_PROD_WIDTH+1){1'b0}}, {(DOT_PROD_WIDTH-1){1'b1}}};
  localparam logic signed [CALC_W-1:0] S_MIN =
    {{(CALC_W-DOT_PROD_WIDTH+1){1'b1}}, {(DOT_PROD_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, F_REQ, F_WAIT, DONE} state_e;

  state_e                             state_q;
  logic [RW-1:0]                      row_q;
  logic [CW-1:0]                      col_q;
  logic [WTW-1:0]                     wait_q;
  logic                               relu_q;
  logic [FEATURE_COLS*DATA_WIDTH-1:0] scratch_q;
  logic [ADDRESS_WIDTH-1:0]           read_address_q;
  logic                               enable_read_q;
  logic                               busy_q;
  logic                               done_q;
  logic [DOT_PROD_WIDTH-1:0]          result_q [FEATURE_ROWS][WEIGHT_COLS];

  logic signed [CALC_W-1:0]           acc;
  logic [DOT_PROD_WIDTH-1:0]          result_d;

  function automatic logic signed [CALC_W-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED) ext = {{(CALC_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    else        ext = {{(CALC_W-DATA_WIDTH){1'b0}}, v};
  endfunction

  // Dot product of the element currently on data_in with the buffered column,
  // followed by optional ReLU and saturation to the result width.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc      = '0;
    for (int k = 0; k < FEATURE_COLS; k++) begin
      acc = acc + ext(data_in[k*DATA_WIDTH +: DATA_WIDTH])
                * ext(scratch_q[k*DATA_WIDTH +: DATA_WIDTH]);
    end
    result_d = acc[DOT_PROD_WIDTH-1:0];
    if (!SIGNED) begin
      if (acc > U_MAX) result_d = U_MAX[DOT_PROD_WIDTH-1:0];
    end else begin
      if (relu_q && acc[CALC_W-1]) result_d = '0;
      else if (acc > S_MAX)        result_d = S_MAX[DOT_PROD_WIDTH-1:0];
      else if (acc < S_MIN)        result_d = S_MIN[DOT_PROD_WIDTH-1:0];
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      wait_q         <= '0;
      relu_q         <= 1'b0;
      scratch_q      <= '0;
      read_address_q <= '0;
      enable_read_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      // NOTE: the result memory is reset as well, because a reset run must
      // never leave stale rows visible to the aggregation stage. This keeps
      // it in flops rather than RAM.
      for (int r = 0; r < FEATURE_ROWS; r++)
        for (int c = 0; c < WEIGHT_COLS; c++)
          result_q[r][c] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            row_q          <= '0;
            col_q          <= '0;
            wait_q         <= '0;
            relu_q         <= relu_en;
            state_q        <= W_REQ;
            enable_read_q  <= 1'b1;
            read_address_q <= ADDRESS_WIDTH'(WEIGHT_BASE);
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
          end
        end
        W_REQ: begin
          enable_read_q <= 1'b0;
          wait_q        <= '0;
          state_q       <= W_WAIT;
        end
        W_WAIT: begin
          if (wait_q == WTW'(MEM_LATENCY - 1)) begin
            scratch_q      <= data_in;
            wait_q         <= '0;
            state_q        <= F_REQ;
            enable_read_q  <= 1'b1;
            read_address_q <= ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(row_q);
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        F_REQ: begin
          enable_read_q <= 1'b0;
          wait_q        <= '0;
          state_q       <= F_WAIT;
        end
        F_WAIT: begin
          if (wait_q == WTW'(MEM_LATENCY - 1)) begin
            result_q[row_q][col_q] <= result_d;
            wait_q                 <= '0;
            if (row_q < RW'(FEATURE_ROWS - 1)) begin
              row_q          <= row_q + 1'b1;
              state_q        <= F_REQ;
              enable_read_q  <= 1'b1;
              read_address_q <= ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(row_q) + 1'b1;
            end else if (col_q < CW'(WEIGHT_COLS - 1)) begin
              row_q          <= '0;
              col_q          <= col_q + 1'b1;
              state_q        <= W_REQ;
              enable_read_q  <= 1'b1;
              read_address_q <= ADDRESS_WIDTH'(WEIGHT_BASE) + ADDRESS_WIDTH'(col_q) + 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational row read; rows beyond the matrix read as zero.
  always_comb begin
    fm_wm_row = '0;
    if (int'(read_row) < FEATURE_ROWS) begin
      for (int c = 0; c < WEIGHT_COLS; c++)
        fm_wm_row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = result_q[read_row][c];
    end
  end

  assign read_address = read_address_q;
  assign enable_read  = enable_read_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_transformation_engine.sv
`timescale 1ns/1ps
module tb_transformation_engine;

  localparam int FR = 6, FC = 96, WC = 3, DW = 5, PW = 16, AW = 13;

  logic clk, reset, start, relu_en;
  logic [2:0] read_row;

  // Three instances share stimulus: defaults, signed mode, and 3-cycle memory.
  logic [FC*DW-1:0] data_def, data_sgn, data_lat;
  logic [AW-1:0]    addr_def, addr_sgn, addr_lat;
  logic             en_def, en_sgn, en_lat;
  logic [WC*PW-1:0] fm_def, fm_sgn, fm_lat;
  logic             busy_def, busy_sgn, busy_lat;
  logic             done_def, done_sgn, done_lat;

  transformation_engine u_def (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .data_in(data_def), .read_row(read_row), .read_address(addr_def),
    .enable_read(en_def), .fm_wm_row(fm_def), .busy(busy_def), .done(done_def));

  transformation_engine #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .data_in(data_sgn), .read_row(read_row), .read_address(addr_sgn),
    .enable_read(en_sgn), .fm_wm_row(fm_sgn), .busy(busy_sgn), .done(done_sgn));

  transformation_engine #(.MEM_LATENCY(3)) u_lat (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .data_in(data_lat), .read_row(read_row), .read_address(addr_lat),
    .enable_read(en_lat), .fm_wm_row(fm_lat), .busy(busy_lat), .done(done_lat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory contents: weight columns and feature rows.
  logic [DW-1:0] wmem [WC][FC];
  logic [DW-1:0] fmem [FR][FC];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [FC*DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [FC*DW-1:0] v = '0;
    for (int k = 0; k < FC; k++) begin
      if (int'(a) < WC)                         v[k*DW +: DW] = wmem[int'(a)][k];
      else if (int'(a) >= 512 && int'(a) < 518) v[k*DW +: DW] = fmem[int'(a) - 512][k];
    end
    return v;
  endfunction

  // Memory models: data appears MEM_LATENCY cycles after the strobe.
  logic [FC*DW-1:0] p_lat [3];
  always @(posedge clk) begin
    if (en_def) data_def <= mem_word(addr_def);
    if (en_sgn) data_sgn <= mem_word(addr_sgn);
    if (en_lat) p_lat[0] <= mem_word(addr_lat);
    p_lat[1] <= p_lat[0];
    p_lat[2] <= p_lat[1];
  end
  assign data_lat = p_lat[2];

  // Reference: plain integer dot product, then ReLU and clamping.
  function automatic logic [PW-1:0] model(input int r, input int c, input bit sgn, input bit relu);
    int s = 0;
    int fv, wv;
    for (int k = 0; k < FC; k++) begin
      fv = sgn ? int'($signed(fmem[r][k])) : int'(fmem[r][k]);
      wv = sgn ? int'($signed(wmem[c][k])) : int'(wmem[c][k]);
      s += fv * wv;
    end
    if (!sgn) begin
      if (s > 65535) s = 65535;
    end else begin
      if (relu && s < 0) s = 0;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
    end
    return PW'(s);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd, input int fv, input int wv);
    for (int k = 0; k < FC; k++) begin
      for (int r = 0; r < FR; r++) fmem[r][k] = rnd ? DW'($urandom) : DW'(fv);
      for (int c = 0; c < WC; c++) wmem[c][k] = rnd ? DW'($urandom) : DW'(wv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {busy_def, busy_sgn, busy_lat}, 3'b000);
    check({tag, "_done"}, {done_def, done_sgn, done_lat}, 3'b000);
    check({tag, "_en"},   {en_def, en_sgn, en_lat}, 3'b000);
    check({tag, "_addr"}, {addr_def, addr_sgn, addr_lat}, '0);
    for (int r = 0; r < FR; r++) begin
      read_row = 3'(r);
      #1;
      check($sformatf("%s_rows_r%0d", tag, r), {fm_def, fm_sgn, fm_lat}, '0);
    end
  endtask

  task automatic check_results(input bit relu);
    logic [PW-1:0] eu, es;
    for (int r = 0; r < 8; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < WC; c++) begin
        eu = (r < FR) ? model(r, c, 1'b0, 1'b0) : '0;
        es = (r < FR) ? model(r, c, 1'b1, relu) : '0;
        check($sformatf("def_r%0d_c%0d", r, c), fm_def[c*PW +: PW], eu);
        check($sformatf("lat_r%0d_c%0d", r, c), fm_lat[c*PW +: PW], eu);
        check($sformatf("sgn_r%0d_c%0d", r, c), fm_sgn[c*PW +: PW], es);
      end
    end
  endtask

  // One full product. start is sampled at edge 0; sample n is taken 1 ns
  // after edge n. A second start pulse is applied at edge glitch_at (if >0).
  // relu_en is flipped during the run to confirm it is latched at start.
  task automatic run(input int glitch_at);
    int t_def = -1, t_sgn = -1, t_lat = -1, busy_cnt = 0, bad_gap = 0, last_en = -1;
    logic [AW-1:0] exp_addr [$];
    logic [AW-1:0] got_def [$];
    logic [AW-1:0] got_lat [$];
    logic saved_relu = relu_en;
    for (int c = 0; c < WC; c++) begin
      exp_addr.push_back(AW'(c));
      for (int r = 0; r < FR; r++) exp_addr.push_back(AW'(512 + r));
    end
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        start   = 1'b0;
        relu_en = ~saved_relu;
        check("start_busy", {busy_def, busy_sgn, busy_lat}, 3'b111);
        check("start_done_clr", {done_def, done_sgn, done_lat}, 3'b000);
      end
      if (n == glitch_at - 1) start = 1'b1;
      if (n == glitch_at)     start = 1'b0;
      if (busy_def) busy_cnt++;
      if (en_def) got_def.push_back(addr_def);
      if (en_lat) begin
        got_lat.push_back(addr_lat);
        if (last_en >= 0 && n - last_en != 4) bad_gap++;
        last_en = n;
      end
      if (done_def && t_def < 0) t_def = n;
      if (done_sgn && t_sgn < 0) t_sgn = n;
      if (done_lat && t_lat < 0) t_lat = n;
      if (t_def >= 0 && t_sgn >= 0 && t_lat >= 0) break;
    end
    start   = 1'b0;
    relu_en = saved_relu;
    check("done_edge_def", t_def, 42);
    check("done_edge_sgn", t_sgn, 42);
    check("done_edge_lat", t_lat, 84);
    check("busy_cycles_def", busy_cnt, 42);
    check("done_sticky", {done_def, done_sgn, done_lat, busy_lat}, 4'b1110);
    check("addr_count_def", got_def.size(), 21);
    check("addr_count_lat", got_lat.size(), 21);
    check("strobe_gap_lat", bad_gap, 0);
    for (int i = 0; i < 21; i++) begin
      if (i < got_def.size()) check($sformatf("addr_def_%0d", i), got_def[i], exp_addr[i]);
      if (i < got_lat.size()) check($sformatf("addr_lat_%0d", i), got_lat[i], exp_addr[i]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    relu_en  = 1'b0;
    read_row = '0;
    fill(1'b0, 0, 0);
    // start held during reset must be ignored.
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    start = 1'b0;
    reset = 1'b0;

    // All ones: every result 96.
    fill(1'b0, 1, 1);
    run(-1);
    check_results(1'b0);

    // All 31: unsigned saturates to 65535; signed reads -1*-1.
    fill(1'b0, 31, 31);
    run(-1);
    check_results(1'b0);

    // Features -1, weights 1, with and without ReLU (start from DONE each time).
    fill(1'b0, 31, 1);
    relu_en = 1'b0;
    run(-1);
    check_results(1'b0);
    relu_en = 1'b1;
    run(-1);
    check_results(1'b1);

    // Random data with a stray start in the middle of the run.
    fill(1'b1, 0, 0);
    relu_en = 1'($urandom);
    run(10);
    check_results(relu_en);

    // Reset after edge 20 of a run, then a clean restart.
    fill(1'b1, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_idle("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    fill(1'b1, 0, 0);
    relu_en = 1'($urandom);
    run(-1);
    check_results(relu_en);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/transformation_engine.md
Name: transformation_engine

Overview:
- Parametrised successor of the feature×weight transformation stage: computes FM×WM, where FM is FEATURE_ROWS×FEATURE_COLS and WM is FEATURE_COLS×WEIGHT_COLS, using a single shared external read port.
- Each weight column is buffered once; every feature row is then streamed against it through a one-cycle combinational dot product. Results go into an internal FEATURE_ROWS×WEIGHT_COLS result memory that the downstream aggregation stage reads by row.
- New relative to the previous generation: configurable memory read latency, configurable base addresses, signed mode with optional ReLU, saturating results, a busy flag, and a sticky done.

Parameters:
- FEATURE_ROWS, 6, number of nodes (feature rows).
- FEATURE_COLS, 96, dot-product length; also the width of data_in and of the scratch pad.
- WEIGHT_COLS, 3, number of output columns.
- DATA_WIDTH, 5, width of each feature/weight element.
- DOT_PROD_WIDTH, 16, width of each stored result.
- ADDRESS_WIDTH, 13, width of read_address.
- WEIGHT_BASE, 0, address of weight column 0; column c is at WEIGHT_BASE+c.
- FEATURE_BASE, 512, address of feature row 0; row r is at FEATURE_BASE+r.
- MEM_LATENCY, 1, number of cycles from enable_read to valid data_in; must be ≥1.
- SIGNED, 0, 1 = elements and results are two's complement.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  starts a full matrix product; sampled only in IDLE or DONE.
- relu_en  in  1  clamps negative results to 0; ignored when SIGNED=0; sampled at start.
- data_in  in  FEATURE_COLS×DATA_WIDTH  read data from the external memory.
- read_row  in  $clog2(FEATURE_ROWS)  selects the result-memory row to read.
- read_address  out  ADDRESS_WIDTH  external memory address.
- enable_read  out  1  external read strobe.
- fm_wm_row  out  WEIGHT_COLS×DOT_PROD_WIDTH  combinational read of result row read_row.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (asynchronous) forces:
  - state to IDLE; row counter, column counter and wait counter to 0;
  - scratch pad to 0 and all result entries to 0;
  - read_address=0, enable_read=0, busy=0, done=0.
- FSM states: IDLE, W_REQ, W_WAIT, F_REQ, F_WAIT, DONE.
- IDLE / DONE:
  - start=1 clears both counters, latches relu_en and moves to W_REQ.
  - Leaving DONE deasserts done.
- W_REQ (1 cycle): enable_read=1, read_address=WEIGHT_BASE+col. Next state is W_WAIT.
- W_WAIT (MEM_LATENCY cycles, tracked by the wait counter): enable_read=0.
  - On the final cycle, capture data_in into the scratch pad and go to F_REQ.
- F_REQ (1 cycle): enable_read=1, read_address=FEATURE_BASE+row. Next state is F_WAIT.
- F_WAIT (MEM_LATENCY cycles): on the final cycle, write result[row][col] = f(Σ data_in[k]×scratch[k]).
  - If row<FEATURE_ROWS-1: increment row, go to F_REQ.
  - Else if col<WEIGHT_COLS-1: clear row, increment col, go to W_REQ.
  - Else go to DONE.
- read_address holds its last value outside the REQ states.
- Arithmetic:
  - Products and the sum are full precision (2·DATA_WIDTH+$clog2(FEATURE_COLS) bits) before the final function f.
  - SIGNED=0: f saturates to 2^DOT_PROD_WIDTH−1.
  - SIGNED=1: f first applies ReLU if enabled, then saturates to [−2^(DOT_PROD_WIDTH−1), 2^(DOT_PROD_WIDTH−1)−1].
- Timing:
  - Run length is WEIGHT_COLS·(FEATURE_ROWS+1)·(MEM_LATENCY+1) edges after the start-sampling edge; with defaults this is 42 edges.
  - done is high from that edge and stays high until the next start or reset.
- The result memory is not cleared at start; each entry is overwritten during the run.
- Boundary cases:
  - A result written on an edge is visible on fm_wm_row immediately after that edge.
  - start while busy is ignored.
  - start and reset in the same cycle: reset wins.
  - Reset mid-run returns to IDLE and zeroes the results; there is no partial done.
  - read_row ≥ FEATURE_ROWS returns all zeros.

Test Plan:
- Defaults, memory model returns all weights=1 and all features=1 → every result = 96; done high exactly 42 edges after start; busy high for those 42 cycles; read_address sequence is 0, 512..517, 1, 512..517, 2, 512..517.
- All elements =31, SIGNED=0 → raw sum 92256 saturates to 65535 in all 18 entries.
- SIGNED=1, features=−1, weights=1, relu_en=0 → all results −96 (0xFFA0); repeat with relu_en=1 → all results 0.
- MEM_LATENCY=3 → enable_read pulses every 4 cycles; scratch pad captures on the 3rd wait cycle; done after 3·7·4=84 edges; results match golden.
- Assert reset at edge 20 mid-run → immediate IDLE, outputs 0, fm_wm_row=0 for all rows; a restart then completes correctly.
- start pulsed at edge 10 of a run → ignored, timing unchanged; start asserted while in DONE → done drops the next cycle and a second run overwrites results with the new data.
